// File: rtl/dmem_axil_bridge_if.sv
// AXI4-Lite bus bundle between the data-memory bridge (master)
// and the interconnect or slave.
interface dmem_axil_bridge_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] m_awaddr;
   logic            m_awvalid;
   logic            m_awready;
   logic [XLEN-1:0] m_wdata;
   logic [3:0]      m_wstrb;
   logic            m_wvalid;
   logic            m_wready;
   logic [1:0]      m_bresp;
   logic            m_bvalid;
   logic            m_bready;
   logic [XLEN-1:0] m_araddr;
   logic            m_arvalid;
   logic            m_arready;
   logic [XLEN-1:0] m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rvalid;
   logic            m_rready;

   modport master (
      output m_awaddr, m_awvalid,
      input  m_awready,
      output m_wdata, m_wstrb, m_wvalid,
      input  m_wready,
      input  m_bresp, m_bvalid,
      output m_bready,
      output m_araddr, m_arvalid,
      input  m_arready,
      input  m_rdata, m_rresp, m_rvalid,
      output m_rready
   );

   modport slave (
      input  m_awaddr, m_awvalid,
      output m_awready,
      input  m_wdata, m_wstrb, m_wvalid,
      output m_wready,
      output m_bresp, m_bvalid,
      input  m_bready,
      input  m_araddr, m_arvalid,
      output m_arready,
      output m_rdata, m_rresp, m_rvalid,
      input  m_rready
   );
endinterface

// File: rtl/dmem_axil_bridge.sv
// Core data-memory port to AXI4-Lite master bridge: one access in
// flight, lane alignment, watchdog and sticky error status.
module dmem_axil_bridge #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 256,
   parameter int TO_W    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dmem_req,
   input  logic              dmem_cmd,
   input  logic [1:0]        dmem_width,
   input  logic [XLEN-1:0]   dmem_addr,
   input  logic [XLEN-1:0]   dmem_wdata,
   output logic [XLEN-1:0]   dmem_rdata,
   output logic              dmem_resp,
   dmem_axil_bridge_if.master m,
   input  logic              err_clr,
   output logic              err_misalign,
   output logic              err_bus,
   output logic              err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_RESP
   } state_t;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [1:0]        width_q, width_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              resp_q, resp_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              mis_q, mis_d;
   logic              bus_q, bus_d;
   logic              to_q, to_d;

   logic              misalign;
   logic [3:0]        lane_strb;
   logic [XLEN-1:0]   lane_wdata;
   logic [XLEN-1:0]   sh;
   logic [XLEN-1:0]   rd_lane;
   logic [TO_W-1:0]   cnt_inc;
   logic              busy;
   logic              wd_fire;
   logic              mis_set, bus_set, to_set;

   // Request-side lane steering and rdata extraction.
   always_comb begin
      misalign = ((dmem_width == 2'd1) && dmem_addr[0])
               || (dmem_width[1] && (dmem_addr[1:0] != 2'b00));
      lane_strb  = 4'b1111;
      lane_wdata = dmem_wdata;
      unique case (dmem_width)
         2'd0: begin
            lane_strb  = 4'b0001 << dmem_addr[1:0];
            lane_wdata = {4{dmem_wdata[7:0]}};
         end
         2'd1: begin
            lane_strb  = 4'b0011 << dmem_addr[1:0];
            lane_wdata = {2{dmem_wdata[15:0]}};
         end
         default: begin
            lane_strb  = 4'b1111;
            lane_wdata = dmem_wdata;
         end
      endcase
      sh = m.m_rdata >> {addr_q[1:0], 3'b000};
      unique case (width_q)
         2'd0:    rd_lane = {{(XLEN-8){1'b0}}, sh[7:0]};
         2'd1:    rd_lane = {{(XLEN-16){1'b0}}, sh[15:0]};
         default: rd_lane = sh;
      endcase
   end

   // Next-state, handshake and watchdog logic.
   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      resp_d    = 1'b0;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      mis_set   = 1'b0;
      bus_set   = 1'b0;
      to_set    = 1'b0;
      cnt_inc   = cnt_q + TO_W'(1);
      busy      = (state_q == S_WRITE) || (state_q == S_WRESP)
               || (state_q == S_RADDR) || (state_q == S_RDATA);
      wd_fire   = (TIMEOUT != 0) && busy && (cnt_inc == TO_LIM);
      if (busy) cnt_d = cnt_inc;
      unique case (state_q)
         S_IDLE: begin
            if (dmem_req) begin
               width_d = dmem_width;
               addr_d  = dmem_addr;
               wdata_d = lane_wdata;
               wstrb_d = lane_strb;
               cnt_d   = '0;
               rdata_d = '0;
               if (misalign) begin
                  mis_set = 1'b1;
                  state_d = S_RESP;
               end else if (dmem_cmd) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WRITE;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = S_RADDR;
               end
            end
         end
         S_WRITE: begin
            awvalid_d = awvalid_q & ~m.m_awready;
            wvalid_d  = wvalid_q & ~m.m_wready;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_WRESP;
            end
         end
         S_WRESP: begin
            if (m.m_bvalid) begin
               bready_d = 1'b0;
               bus_set  = (m.m_bresp != 2'b00);
               resp_d   = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RADDR: begin
            if (m.m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RDATA;
            end
         end
         S_RDATA: begin
            if (m.m_rvalid) begin
               rready_d = 1'b0;
               rdata_d  = rd_lane;
               bus_set  = (m.m_rresp != 2'b00);
               resp_d   = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            // Misaligned entry arrives with resp low and pulses next cycle.
            if (resp_q) state_d = S_IDLE;
            else        resp_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (wd_fire) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
         rdata_d   = '0;
         bus_set   = 1'b0;
         to_set    = 1'b1;
         resp_d    = 1'b1;
         state_d   = S_RESP;
      end
      mis_d = mis_set | (mis_q & ~err_clr);
      bus_d = bus_set | (bus_q & ~err_clr);
      to_d  = to_set  | (to_q  & ~err_clr);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         width_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         resp_q    <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         mis_q     <= 1'b0;
         bus_q     <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         width_q   <= width_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         mis_q     <= mis_d;
         bus_q     <= bus_d;
         to_q      <= to_d;
      end
   end

   assign m.m_awaddr   = {addr_q[XLEN-1:2], 2'b00};
   assign m.m_araddr   = {addr_q[XLEN-1:2], 2'b00};
   assign m.m_awvalid  = awvalid_q;
   assign m.m_wdata    = wdata_q;
   assign m.m_wstrb    = wstrb_q;
   assign m.m_wvalid   = wvalid_q;
   assign m.m_bready   = bready_q;
   assign m.m_arvalid  = arvalid_q;
   assign m.m_rready   = rready_q;
   assign dmem_rdata   = rdata_q;
   assign dmem_resp    = resp_q;
   assign err_misalign = mis_q;
   assign err_bus      = bus_q;
   assign err_timeout  = to_q;

endmodule
